// File: rtl/matrix_bus_master.sv
// Bus-master sequencer for the matrix accelerator slave: it loads the A and B operands,
// starts the operation, waits for the interrupt, reads the results back and clears the job.
module matrix_bus_master #(
  parameter logic [7:0] S_BASE = 8'h00,
  parameter int         N_ELEM = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_start,
  input  logic        op_sel,
  input  logic [31:0] a_data,
  input  logic [31:0] b_data,
  output logic [2:0]  src_idx,
  output logic        M_req,
  input  logic        M_grant,
  output logic [7:0]  M_address,
  output logic        M_wr,
  output logic [31:0] M_dout,
  input  logic [31:0] M_din,
  input  logic        m_interrupt,
  output logic        res_we,
  output logic [2:0]  res_idx,
  output logic [31:0] res_data,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] LAST = 3'(N_ELEM - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_WR_A, S_WR_B, S_WR_INT, S_START,
    S_WAIT, S_CLR_INT, S_READ, S_CLEAR, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        op_sel_q, op_sel_d;
  logic        res_we_q, res_we_d;
  logic [2:0]  res_idx_q, res_idx_d;
  logic [31:0] res_data_q, res_data_d;
  logic        xfer;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      op_sel_q   <= 1'b0;
      res_we_q   <= 1'b0;
      res_idx_q  <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      op_sel_q   <= op_sel_d;
      res_we_q   <= res_we_d;
      res_idx_q  <= res_idx_d;
      res_data_q <= res_data_d;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    op_sel_d   = op_sel_q;
    res_we_d   = 1'b0;
    res_idx_d  = res_idx_q;
    res_data_d = res_data_q;
    case (state_q)
      S_IDLE: if (op_start) begin
        state_d  = S_REQ;
        op_sel_d = op_sel;
      end
      S_REQ: if (M_grant) begin
        state_d = S_WR_A;
        idx_d   = '0;
      end
      S_WR_A, S_WR_B: if (M_grant) begin
        if (idx_q == LAST) begin
          state_d = (state_q == S_WR_A) ? S_WR_B : S_WR_INT;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_WR_INT:  if (M_grant) state_d = S_START;
      S_START:   if (M_grant) state_d = S_WAIT;
      S_WAIT:    if (m_interrupt) state_d = S_CLR_INT;
      S_CLR_INT: if (M_grant) begin
        state_d = S_READ;
        idx_d   = '0;
      end
      S_READ: begin
        if (M_grant) begin
          res_we_d   = 1'b1;
          res_idx_d  = idx_q;
          res_data_d = M_din;
          if (idx_q == LAST) begin
            state_d = S_CLEAR;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          // A non-write cycle rewinds the slave read pointer, so the burst starts over.
          idx_d = '0;
        end
      end
      S_CLEAR: if (M_grant) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    M_req     = 1'b0;
    xfer      = 1'b0;
    M_address = S_BASE + 8'd7;
    M_dout    = '0;
    case (state_q)
      S_REQ, S_WAIT: M_req = 1'b1;
      S_WR_A: begin
        M_req = 1'b1; xfer = 1'b1; M_address = S_BASE; M_dout = a_data;
      end
      S_WR_B: begin
        M_req = 1'b1; xfer = 1'b1; M_address = S_BASE + 8'd1; M_dout = b_data;
      end
      S_WR_INT: begin
        M_req = 1'b1; xfer = 1'b1; M_address = S_BASE + 8'd2; M_dout = 32'h1;
      end
      S_START: begin
        M_req = 1'b1; xfer = 1'b1; M_dout = 32'h1;
        M_address = op_sel_q ? (S_BASE + 8'd4) : (S_BASE + 8'd3);
      end
      S_CLR_INT: begin
        M_req = 1'b1; xfer = 1'b1; M_address = S_BASE + 8'd2;
      end
      S_READ: begin
        M_req = 1'b1; xfer = 1'b1; M_address = S_BASE + 8'd6;
      end
      S_CLEAR: begin
        M_req = 1'b1; xfer = 1'b1; M_address = S_BASE + 8'd5; M_dout = 32'h1;
      end
      default: ;
    endcase
  end

  assign M_wr     = xfer & M_grant;
  assign src_idx  = idx_q;
  assign res_we   = res_we_q;
  assign res_idx  = res_idx_q;
  assign res_data = res_data_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_matrix_bus_master.sv
// Directed bench for matrix_bus_master: a small slave model drives the read data,
// and each job's bus writes and result strobes are checked against hand-built sequences.
module tb_matrix_bus_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_start = 1'b0;
  logic        op_sel = 1'b0;
  logic [31:0] a_data, b_data;
  logic [2:0]  src_idx;
  logic        M_req;
  logic        M_grant = 1'b1;
  logic [7:0]  M_address;
  logic        M_wr;
  logic [31:0] M_dout;
  logic [31:0] M_din;
  logic        m_interrupt = 1'b0;
  logic        res_we;
  logic [2:0]  res_idx;
  logic [31:0] res_data;
  logic        busy, done;

  matrix_bus_master dut (
    .clk(clk), .reset(reset), .op_start(op_start), .op_sel(op_sel),
    .a_data(a_data), .b_data(b_data), .src_idx(src_idx),
    .M_req(M_req), .M_grant(M_grant), .M_address(M_address), .M_wr(M_wr),
    .M_dout(M_dout), .M_din(M_din), .m_interrupt(m_interrupt),
    .res_we(res_we), .res_idx(res_idx), .res_data(res_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Operand memories: A[i] = i+1, B[i] = 16*(i+1).
  assign a_data = 32'(src_idx) + 32'd1;
  assign b_data = (32'(src_idx) + 32'd1) << 4;

  // Slave read pointer: advances on writes to offset 6, rewinds on any non-write cycle.
  logic [31:0] rptr = '0;
  logic [31:0] rptr_nxt = '0;
  assign M_din = 32'hC0DE0000 + rptr;
  always @(posedge clk) rptr <= rptr_nxt;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor, sampled mid-cycle.
  int          cyc = 0;
  int          req_cyc = 0, done_cyc = 0, done_cnt = 0;
  int          wra_cnt = 0, wrb_cnt = 0, rd_cnt = 0, start_cnt = 0, clr_int_cnt = 0;
  logic        prev_busy = 1'b0;
  logic [39:0] wr_log[$];
  logic [34:0] res_log[$];

  always @(negedge clk) begin
    cyc++;
    if (busy && !prev_busy) req_cyc = cyc;
    prev_busy = busy;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (M_wr) begin
      wr_log.push_back({M_address, M_dout});
      case (M_address)
        8'h00: wra_cnt++;
        8'h01: wrb_cnt++;
        8'h02: if (M_dout == 32'h0) clr_int_cnt++;
        8'h03, 8'h04: start_cnt++;
        8'h06: rd_cnt++;
        default: ;
      endcase
    end
    rptr_nxt = !M_wr ? 32'h0 : (M_address == 8'h06 ? rptr + 32'd1 : rptr);
    if (res_we) res_log.push_back({res_idx, res_data});
  end

  task automatic run_job(input bit sel, input int w, input int a_at, input int a_len,
                         input int r_at, input bit poke, input bit late);
    logic [39:0] exp_q[$];
    int wr0 = wr_log.size();
    int rs0 = res_log.size();
    int d0 = done_cnt, a0 = wra_cnt, rd0 = rd_cnt, s0 = start_cnt, c0 = clr_int_cnt;
    int n_reads = (r_at >= 0) ? 8 + r_at : 8;
    int extra = ((a_at >= 0) ? a_len : 0) + ((r_at >= 0) ? r_at + 1 : 0);
    int wait_c = 0, stall_left = 0;
    bit fired_a = 0, fired_r = 0;
    int n_got, n_chk;

    for (int i = 0; i < 8; i++) exp_q.push_back({8'h00, 32'(i + 1)});
    for (int i = 0; i < 8; i++) exp_q.push_back({8'h01, 32'(16 * (i + 1))});
    exp_q.push_back({8'h02, 32'h1});
    exp_q.push_back({sel ? 8'h04 : 8'h03, 32'h1});
    exp_q.push_back({8'h02, 32'h0});
    for (int i = 0; i < n_reads; i++) exp_q.push_back({8'h06, 32'h0});
    exp_q.push_back({8'h05, 32'h1});

    op_sel = sel;
    op_start = 1'b1;
    cycle();
    op_start = 1'b0;
    for (int n = 0; n < 5000 && done_cnt == d0; n++) begin
      M_grant = 1'b1;
      op_start = 1'b0;
      if (a_at >= 0 && !fired_a && wra_cnt - a0 == a_at) begin
        fired_a = 1; stall_left = a_len;
      end
      if (r_at >= 0 && !fired_r && rd_cnt - rd0 == r_at) begin
        fired_r = 1; stall_left = 1;
      end
      if (stall_left > 0) begin
        M_grant = 1'b0;
        stall_left--;
        #1 check("stall_wr", 64'(M_wr), 64'd0);
      end
      if (start_cnt - s0 == 1 && clr_int_cnt == c0 && !m_interrupt) begin
        wait_c++;
        if (poke && wait_c == 5) begin
          op_start = 1'b1;
          op_sel = ~sel;
        end
        if (late && wait_c == w - 1) begin
          #1;
          check("late_wr", 64'(M_wr), 64'd0);
          check("late_addr", 64'(M_address), 64'h07);
          check("late_busy", 64'(busy), 64'd1);
        end
        if (wait_c == w) m_interrupt = 1'b1;
      end
      if (clr_int_cnt != c0) m_interrupt = 1'b0;
      cycle();
    end
    m_interrupt = 1'b0;
    cycle();
    check("done_pulses", 64'(done_cnt - d0), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_done", 64'(done), 64'd0);
    check("duration", 64'(done_cyc - req_cyc + 1), 64'(30 + w + extra));

    n_got = wr_log.size() - wr0;
    check("n_writes", 64'(n_got), 64'(exp_q.size()));
    n_chk = (n_got < exp_q.size()) ? n_got : exp_q.size();
    for (int k = 0; k < n_chk; k++)
      check($sformatf("wr[%0d]", k), 64'(wr_log[wr0 + k]), 64'(exp_q[k]));

    check("n_results", 64'(res_log.size() - rs0), 64'(n_reads));
    if (res_log.size() - rs0 >= 8)
      for (int i = 0; i < 8; i++)
        check($sformatf("res[%0d]", i), 64'(res_log[res_log.size() - 8 + i]),
              64'({3'(i), 32'hC0DE0000 + 32'(i)}));
  endtask

  initial begin
    int b0;
    cycle();
    cycle();
    check("rst_req", 64'(M_req), 64'd0);
    check("rst_wr", 64'(M_wr), 64'd0);
    check("rst_addr", 64'(M_address), 64'h07);
    check("rst_dout", 64'(M_dout), 64'd0);
    check("rst_src", 64'(src_idx), 64'd0);
    check("rst_res", 64'({res_we, res_idx, res_data}), 64'd0);
    check("rst_busy", 64'({busy, done}), 64'd0);
    reset = 1'b0;
    cycle();

    run_job(1'b0, 20, -1, 0, -1, 1'b0, 1'b0);   // nominal multiply
    run_job(1'b1, 12, -1, 0, -1, 1'b1, 1'b0);   // add, op_start poked during WAIT
    run_job(1'b0, 5, 4, 3, -1, 1'b0, 1'b0);     // grant stall at WR_A i=4
    run_job(1'b0, 7, -1, 0, 5, 1'b0, 1'b0);     // grant loss at READ i=5

    // Reset in the middle of WR_B.
    b0 = wrb_cnt;
    op_sel = 1'b0;
    op_start = 1'b1;
    cycle();
    op_start = 1'b0;
    for (int n = 0; n < 100 && wrb_cnt - b0 < 3; n++) cycle();
    check("in_wr_b", 64'(wrb_cnt - b0), 64'd3);
    reset = 1'b1;
    #1;
    check("mid_rst_req", 64'(M_req), 64'd0);
    check("mid_rst_wr", 64'(M_wr), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_addr", 64'(M_address), 64'h07);
    cycle();
    reset = 1'b0;
    cycle();
    check("post_rst_busy", 64'(busy), 64'd0);
    run_job(1'b0, 3, -1, 0, -1, 1'b0, 1'b0);

    run_job(1'b0, 1000, -1, 0, -1, 1'b0, 1'b1); // late interrupt

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/matrix_bus_master.md
# matrix_bus_master

Bus-master sequencer that drives the matrix accelerator's slave register map from the initiator side. It loads eight A and eight B operands into the slave FIFOs, arms the interrupt, starts a multiply or add, waits for the interrupt, reads back eight results, and clears the operation. It sits between the system controller (op_start/done) and the shared bus.

## Interface
- S_BASE, 8'h00, slave base address; register offsets are added to it.
- N_ELEM, 8, operands per matrix and results per job; the index width is 3 bits.
- clk  in  1  system clock, all logic on the rising edge
- reset  in  1  asynchronous, active-high reset
- op_start  in  1  one-cycle job request, sampled only in IDLE
- op_sel  in  1  operation select, captured with op_start: 0 = multiply (offset 3), 1 = add (offset 4)
- a_data  in  32  operand A[src_idx], combinational read
- b_data  in  32  operand B[src_idx], combinational read
- src_idx  out  3  operand index
- M_req  out  1  bus request
- M_grant  in  1  bus grant
- M_address  out  8  bus address
- M_wr  out  1  write strobe
- M_dout  out  32  write data
- M_din  in  32  read data, valid in the same cycle as M_address
- m_interrupt  in  1  slave operation-done interrupt
- res_we  out  1  result write strobe
- res_idx  out  3  result index
- res_data  out  32  result word
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse at job end

## Operation
- States and transitions:
  - IDLE: go to REQ on op_start.
  - REQ: go to WR_A when M_grant = 1.
  - WR_A: i = 0..7, address S_BASE+0, M_wr = 1, M_dout = a_data, src_idx = i.
  - WR_B: same pattern at S_BASE+1 with b_data.
  - WR_INT: write 32'h1 to S_BASE+2.
  - START: write 32'h1 to S_BASE+3 (op_sel = 0) or S_BASE+4 (op_sel = 1).
  - WAIT: address S_BASE+7, M_wr = 0; leave when m_interrupt = 1.
  - CLR_INT: write 32'h0 to S_BASE+2. This drops m_interrupt, which unfreezes the slave read pointer.
  - READ: i = 0..7, address S_BASE+6, M_wr = 1, M_dout = 0; capture M_din as result i. The slave pointer advances on each such cycle and resets to 0 on any cycle with M_wr = 0.
  - CLEAR: write 32'h1 to S_BASE+5.
  - DONE: M_req = 0, done = 1, then IDLE.
- Bus outputs in a transfer state:
  - Outputs are decoded from the state and index registers.
  - M_wr = 1 only when M_grant = 1 in that cycle.
  - With M_grant = 0, M_wr = 0 and the index holds.
- Grant loss in READ restarts READ at i = 0, because the slave pointer reset to 0.
- M_req stays high from REQ through CLEAR.
- Outside transfer states: M_address = S_BASE+7, M_dout = 0, M_wr = 0.
- op_start during busy is ignored; op_sel is not re-sampled.
- The block assumes the slave FIFOs are empty at job start; no FIFO-count handshake exists.
- A reset mid-job returns immediately to IDLE with all reset values; no slave cleanup write is issued.

## Timing
- Reset values:
  - M_req = 0, M_wr = 0, M_address = S_BASE+7, M_dout = 0.
  - src_idx = 0, res_we = 0, res_idx = 0, res_data = 0.
  - busy = 0, done = 0.
- op_start in cycle 0 puts the block in REQ in cycle 1.
- With a constant grant, the states last:
  - REQ: 1 cycle.
  - WR_A: 8 cycles.
  - WR_B: 8 cycles.
  - WR_INT: 1 cycle.
  - START: 1 cycle.
  - WAIT: W cycles.
  - CLR_INT: 1 cycle.
  - READ: 8 cycles.
  - CLEAR: 1 cycle.
  - DONE: 1 cycle.
- Total job time is 30+W cycles from REQ entry to the done pulse.
- WAIT exit: m_interrupt sampled high at edge k puts the block in CLR_INT in cycle k+1.
- res_we, res_idx and res_data are registered, one cycle after the READ cycle that sampled M_din. res_we pulses 8 times per job, with res_idx 0..7 in order.
- done is high for exactly one cycle; busy falls in the cycle after done.

## Test plan
- Nominal multiply:
  - Stimulus: A[i] = i+1, B[i] = 16*(i+1), grant tied 1, op_sel = 0, m_interrupt after 20 cycles, M_din = 32'hC0DE0000 + rAddr.
  - Response: 8 writes to 0x00 then 8 to 0x01 with matching data, write of 1 to 0x02, write of 1 to 0x03.
  - Response: write of 0 to 0x02, then 8 res_we with res_data = 32'hC0DE0000..07.
  - Response: write of 1 to 0x05; done 50 cycles after REQ entry.
- Add select: op_sel = 1 -> the start write goes to 0x04; no write to 0x03 occurs.
- Grant stall:
  - Stimulus: drop M_grant for 3 cycles at WR_A i = 4.
  - Response: M_wr = 0 for those cycles, and writes resume with A[4]; no index is skipped or duplicated.
- Read restart:
  - Stimulus: drop M_grant for 1 cycle at READ i = 5.
  - Response: READ restarts; the final res_idx 0..7 carry the results at slave rAddr 0..7.
- Busy and reset:
  - op_start pulsed during WAIT is ignored.
  - Asserting reset in WR_B forces M_req = 0, M_wr = 0 and busy = 0 immediately.
  - The next op_start runs a clean job from WR_A i = 0.
- Late interrupt: m_interrupt held 0 for 1000 cycles -> the block stays in WAIT with M_wr = 0, M_address = S_BASE+7 and busy = 1.
